// File: rtl/axis_pkt_pkg.sv
// Shared types and defaults for the AXI-Stream packet framer and its companions.
package axis_pkt_pkg;

   localparam int DW_DEF = 8;
   localparam int LW_DEF = 8;

   typedef enum logic {
      PASS = 1'b0,
      PAD  = 1'b1
   } state_e;

   // Sideband carried with each framed beat so the event pulses line up with
   // the handshake of the beat that closes the packet.
   typedef struct packed {
      logic split;
      logic pad;
   } evt_t;

   localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/axis_reg_slice.sv
// Single registered AXI-Stream output stage; holds its beat until accepted.
module axis_reg_slice #(
   parameter int W  = 8,
   parameter int UW = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [W-1:0]  data_i,
   input  logic          last_i,
   input  logic [UW-1:0] user_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [W-1:0]  data_o,
   output logic          last_o,
   output logic [UW-1:0] user_o,
   output logic          free_o
);

   logic          valid_q;
   logic [W-1:0]  data_q;
   logic          last_q;
   logic [UW-1:0] user_q;

   // The slot may be refilled in the same cycle its current beat is taken.
   assign free_o = !valid_q || ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         user_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         last_q  <= last_i;
         user_q  <= user_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;
   assign user_o  = user_q;

endmodule

// File: rtl/axis_packet_framer.sv
// Cuts a raw AXI-Stream into fixed-length packets, zero-padding bursts that
// end early and splitting bursts that run past the packet length.
module axis_packet_framer
   import axis_pkt_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int LW = LW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [LW-1:0] cfg_len,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   output logic          s_tready,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   output logic          m_tlast,
   input  logic          m_tready,
   output logic [15:0]   pkt_count,
   output logic          pad_event,
   output logic          split_event
);

   localparam logic [LW-1:0] ONE = LW'(1);

   function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
      return (len == '0) ? ONE : len;
   endfunction

   state_e        state_q;
   logic [LW-1:0] bcnt_q;
   logic [LW-1:0] cur_len_q;
   logic [15:0]   pkt_count_q;
   logic          pad_event_q;
   logic          split_event_q;

   logic          slot_free;
   logic          pkt_start;
   logic [LW-1:0] len_eff;
   logic          at_last;
   logic          load_d;
   logic [DW-1:0] ld_data_d;
   logic          ld_last_d;
   evt_t          ld_evt_d;
   evt_t          m_evt;
   logic          m_hs;

   assign s_tready  = rst && (state_q == PASS) && slot_free;
   assign pkt_start = (state_q == PASS) && (bcnt_q == '0);
   // The first beat of a packet already uses the freshly sampled length.
   assign len_eff   = pkt_start ? clamp_len(cfg_len) : cur_len_q;
   assign at_last   = (bcnt_q == len_eff - ONE);
   assign m_hs      = m_tvalid && m_tready;

   always_comb begin
      load_d    = 1'b0;
      ld_data_d = '0;
      ld_last_d = at_last;
      ld_evt_d  = '0;
      if (state_q == PASS) begin
         load_d         = s_tvalid && s_tready;
         ld_data_d      = s_tdata;
         ld_evt_d.split = at_last && !s_tlast;
      end else begin
         load_d       = slot_free;
         ld_evt_d.pad = at_last;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= PASS;
         bcnt_q    <= '0;
         cur_len_q <= ONE;
      end else if (load_d) begin
         if (pkt_start) begin
            cur_len_q <= len_eff;
         end
         if (at_last) begin
            bcnt_q  <= '0;
            state_q <= PASS;
         end else begin
            bcnt_q <= bcnt_q + ONE;
            if ((state_q == PASS) && s_tlast) begin
               state_q <= PAD;
            end
         end
      end
   end

   // Completion bookkeeping follows the downstream handshake of the closing beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_count_q   <= '0;
         pad_event_q   <= 1'b0;
         split_event_q <= 1'b0;
      end else begin
         if (m_hs && m_tlast) begin
            pkt_count_q <= pkt_count_q + 16'd1;
         end
         pad_event_q   <= m_hs && m_tlast && m_evt.pad;
         split_event_q <= m_hs && m_tlast && m_evt.split;
      end
   end

   axis_reg_slice #(
      .W  (DW),
      .UW (EVT_W)
   ) u_out (
      .clk_i   (clk),
      .rst_ni  (rst),
      .load_i  (load_d),
      .data_i  (ld_data_d),
      .last_i  (ld_last_d),
      .user_i  (ld_evt_d),
      .ready_i (m_tready),
      .valid_o (m_tvalid),
      .data_o  (m_tdata),
      .last_o  (m_tlast),
      .user_o  (m_evt),
      .free_o  (slot_free)
   );

   assign pkt_count   = pkt_count_q;
   assign pad_event   = pad_event_q;
   assign split_event = split_event_q;

endmodule

// File: tb/tb_axis_packet_framer.sv
// Randomised and directed bench for axis_packet_framer with a queue-based framing model.
module tb_axis_packet_framer;

   localparam int DW = 8;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [LW-1:0] cfg_len = 8'd4;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b1;
   logic [15:0]   pkt_count;
   logic          pad_event;
   logic          split_event;

   always #5 clk = ~clk;

   axis_packet_framer #(.DW(DW), .LW(LW)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_len     (cfg_len),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tlast     (s_tlast),
      .s_tready    (s_tready),
      .m_tdata     (m_tdata),
      .m_tvalid    (m_tvalid),
      .m_tlast     (m_tlast),
      .m_tready    (m_tready),
      .pkt_count   (pkt_count),
      .pad_event   (pad_event),
      .split_event (split_event)
   );

   typedef struct {
      logic [DW-1:0] d;
      bit            last;
      bit            pad;
      bit            split;
      bit            padend;
   } beat_t;

   beat_t         exp_q[$];
   int            n_chk = 0;
   int            n_fail = 0;
   int            m_idx = 0;
   int            m_len = 1;
   int            exp_cnt = 0;
   bit            exp_pad = 0;
   bit            exp_split = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_d = '0;
   bit            prev_l = 0;
   logic [DW-1:0] log_d[$];
   bit            log_l[$];
   int            pad_seen = 0;
   int            split_seen = 0;
   int            rdy_pct = 100;
   int            unloaded;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // Framing rules: a packet has len beats (cfg 0 -> 1), sampled at its first
   // beat; early s_tlast appends zero beats up to len; reaching len without
   // s_tlast closes the packet as a split.
   function automatic void model_push(input logic [DW-1:0] d, input bit l, input logic [LW-1:0] cfg);
      beat_t b;
      if (m_idx == 0) m_len = (cfg == 0) ? 1 : int'(cfg);
      b.d = d; b.pad = 0; b.padend = 0;
      b.last  = (m_idx == m_len - 1);
      b.split = (m_idx == m_len - 1) && !l;
      exp_q.push_back(b);
      if (m_idx == m_len - 1) begin
         m_idx = 0;
      end else if (l) begin
         for (int k = m_idx + 1; k < m_len; k++) begin
            b.d = '0; b.pad = 1; b.split = 0;
            b.last   = (k == m_len - 1);
            b.padend = (k == m_len - 1);
            exp_q.push_back(b);
         end
         m_idx = 0;
      end else begin
         m_idx++;
      end
   endfunction

   initial forever begin
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(99) < rdy_pct);
   end

   // Per-cycle compare against the model; handshakes are decided at the next rising edge.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         exp_q.delete();
         m_idx = 0; exp_cnt = 0; exp_pad = 0; exp_split = 0; prev_stall = 0;
         chk("rst_m_tvalid", int'(m_tvalid), 0);
         chk("rst_s_tready", int'(s_tready), 0);
      end else begin
         chk("pkt_count", int'(pkt_count), exp_cnt);
         chk("pad_event", int'(pad_event), int'(exp_pad));
         chk("split_event", int'(split_event), int'(exp_split));
         if (pad_event) pad_seen++;
         if (split_event) split_seen++;
         if (prev_stall) begin
            chk("stall_valid", int'(m_tvalid), 1);
            chk("stall_data", int'(m_tdata), int'(prev_d));
            chk("stall_last", int'(m_tlast), int'(prev_l));
         end
         unloaded = 0;
         foreach (exp_q[i]) if (exp_q[i].pad) unloaded++;
         if (m_tvalid && exp_q.size() > 0 && exp_q[0].pad) unloaded--;
         if (unloaded > 0) chk("s_tready_pad", int'(s_tready), 0);
         else chk("s_tready", int'(s_tready), int'(!m_tvalid || m_tready));
         if (m_tvalid) begin
            if (exp_q.size() == 0) chk("unexpected_beat", int'(m_tvalid), 0);
            else begin
               chk("m_tdata", int'(m_tdata), int'(exp_q[0].d));
               chk("m_tlast", int'(m_tlast), int'(exp_q[0].last));
            end
         end
         exp_pad = 0; exp_split = 0;
         if (m_tvalid && m_tready) begin
            log_d.push_back(m_tdata);
            log_l.push_back(m_tlast);
            if (exp_q.size() > 0) begin
               if (exp_q[0].last) exp_cnt = (exp_cnt + 1) % 65536;
               exp_pad   = exp_q[0].padend;
               exp_split = exp_q[0].split;
               void'(exp_q.pop_front());
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_d = m_tdata;
         prev_l = m_tlast;
         if (s_tvalid && s_tready) model_push(s_tdata, s_tlast, cfg_len);
      end
   end

   task automatic send(input logic [DW-1:0] d, input bit l);
      bit done = 0;
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
      for (int t = 0; t < 2000 && !done; t++) begin
         @(negedge clk);
         done = s_tready;
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      chk("send_accept", int'(done), 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      bit done = 0;
      for (int t = 0; t < 3000 && !done; t++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !m_tvalid;
         @(posedge clk);
         #1;
      end
      chk("drain", int'(done), 1);
      idle(2);
   endtask

   task automatic chk_log(input string nm, input int base, input int n,
                          input int vals[16], input bit lasts[16]);
      chk({nm, "_count"}, log_d.size() - base, n);
      for (int i = 0; i < n && base + i < log_d.size(); i++) begin
         chk({nm, "_data"}, int'(log_d[base + i]), vals[i]);
         chk({nm, "_last"}, int'(log_l[base + i]), int'(lasts[i]));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      int base, ps, ss, pc;
      int vals[16];
      bit lasts[16];
      int cfgs[6] = '{0, 1, 2, 3, 5, 7};

      #2;
      chk("reset_m_tvalid", int'(m_tvalid), 0);
      chk("reset_m_tdata", int'(m_tdata), 0);
      chk("reset_m_tlast", int'(m_tlast), 0);
      chk("reset_pkt_count", int'(pkt_count), 0);
      chk("reset_pad_event", int'(pad_event), 0);
      chk("reset_split_event", int'(split_event), 0);
      chk("reset_s_tready", int'(s_tready), 0);
      idle(3);
      rst = 1'b1;
      idle(1);

      // Length-4 packets cut from a continuous burst.
      cfg_len = 8'd4; base = log_d.size(); ss = split_seen; ps = pad_seen;
      for (int i = 1; i <= 8; i++) send(DW'(i), 0);
      drain();
      vals = '{1,2,3,4,5,6,7,8,0,0,0,0,0,0,0,0};
      lasts = '{0,0,0,1,0,0,0,1,0,0,0,0,0,0,0,0};
      chk_log("split4", base, 8, vals, lasts);
      chk("split4_splits", split_seen - ss, 2);
      chk("split4_pads", pad_seen - ps, 0);
      chk("split4_pkt_count", int'(pkt_count), 2);

      // Short burst padded with zeros.
      base = log_d.size(); ss = split_seen; ps = pad_seen;
      send(8'd9, 0);
      send(8'd10, 1);
      @(negedge clk); chk("pad_s_tready_0", int'(s_tready), 0);
      @(negedge clk); chk("pad_s_tready_1", int'(s_tready), 0);
      @(negedge clk); chk("pad_s_tready_2", int'(s_tready), 1);
      @(posedge clk); #1;
      drain();
      vals = '{9,10,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
      lasts = '{0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0};
      chk_log("pad4", base, 4, vals, lasts);
      chk("pad4_pads", pad_seen - ps, 1);
      chk("pad4_splits", split_seen - ss, 0);
      chk("pad4_pkt_count", int'(pkt_count), 3);

      // Burst end exactly on the packet boundary.
      cfg_len = 8'd3; base = log_d.size(); ss = split_seen; ps = pad_seen;
      send(8'd1, 0); send(8'd2, 0); send(8'd3, 1);
      drain();
      vals = '{1,2,3,0,0,0,0,0,0,0,0,0,0,0,0,0};
      lasts = '{0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
      chk_log("exact3", base, 3, vals, lasts);
      chk("exact3_events", (pad_seen - ps) + (split_seen - ss), 0);
      chk("exact3_pkt_count", int'(pkt_count), 4);

      // Length change mid-packet applies to the following packet only.
      cfg_len = 8'd5; base = log_d.size(); ss = split_seen;
      send(8'd1, 0); send(8'd2, 0);
      cfg_len = 8'd2;
      for (int i = 3; i <= 7; i++) send(DW'(i), 0);
      drain();
      vals = '{1,2,3,4,5,6,7,0,0,0,0,0,0,0,0,0};
      lasts = '{0,0,0,0,1,0,1,0,0,0,0,0,0,0,0,0};
      chk_log("cfgchg", base, 7, vals, lasts);
      chk("cfgchg_splits", split_seen - ss, 2);
      chk("cfgchg_pkt_count", int'(pkt_count), 6);

      // Long packets under random back-pressure.
      cfg_len = 8'd64; rdy_pct = 50; base = log_d.size(); pc = pkt_count;
      for (int i = 0; i < 257; i++) begin
         idle($urandom_range(1));
         send(DW'($urandom), 0);
      end
      idle(300);
      chk("long_beats", log_d.size() - base, 257);
      chk("long_pkts", (int'(pkt_count) - pc + 65536) % 65536, 4);
      if (log_d.size() >= base + 64) chk("long_last63", int'(log_l[base + 63]), 1);

      // Random lengths, random bursts, random back-pressure.
      rdy_pct = 70;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(9) == 0) cfg_len = LW'(cfgs[$urandom_range(5)]);
         idle($urandom_range(2));
         send(DW'($urandom), ($urandom_range(99) < 15));
      end
      send(8'hA5, 1);
      drain();

      // Asynchronous reset in the middle of a packet.
      rdy_pct = 100; cfg_len = 8'd4;
      idle(1);
      send(8'd1, 0); send(8'd2, 0); send(8'd3, 0);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_m_tvalid", int'(m_tvalid), 0);
      chk("midrst_m_tdata", int'(m_tdata), 0);
      chk("midrst_m_tlast", int'(m_tlast), 0);
      chk("midrst_s_tready", int'(s_tready), 0);
      chk("midrst_pkt_count", int'(pkt_count), 0);
      idle(2);
      rst = 1'b1;
      idle(1);
      base = log_d.size();
      for (int i = 5; i <= 8; i++) send(DW'(i), 0);
      drain();
      vals = '{5,6,7,8,0,0,0,0,0,0,0,0,0,0,0,0};
      lasts = '{0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0};
      chk_log("postrst", base, 4, vals, lasts);
      chk("postrst_pkt_count", int'(pkt_count), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
